// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the wait-state data memory responder.
package dmem_responder_pkg;

  localparam int DEPTH_LOG2_DEF = 6;
  localparam int WAIT_DEF       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage for the responder: synchronous write, asynchronous read, no reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // write port; contents intentionally survive reset
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory responder with a fixed number of wait cycles per access.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; samples req, misaligned requests skip to ST_RESP
// ST_WAIT | counting down wait cycles; access happens when cnt hits 0
// ST_RESP | one-cycle ack (err set for misaligned requests)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int WAIT       = WAIT_DEF
) (
  input  logic        clock,
  input  logic        reset_0,
  input  logic        req,
  input  logic        wmem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT);

  state_t                  state;
  logic [3:0]              cnt;
  logic [DEPTH_LOG2-1:0]   word_q;
  logic [31:0]             wdata_q;
  logic                    wmem_q;
  logic                    mem_we;
  logic [31:0]             mem_rdata;
  logic                    aligned;
  logic                    unused_addr;

  assign aligned     = (addr[1:0] == 2'b00);
  // upper address bits alias onto the same words
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];

  // write strobe is gated by reset so a reset on the access edge aborts the write
  assign mem_we = reset_0 && (state == ST_WAIT) && (cnt == 4'd0) && wmem_q;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .waddr (word_q),
    .wdata (wdata_q),
    .raddr (word_q),
    .rdata (mem_rdata)
  );

  // request FSM, wait counter, request latch and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_0) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= 32'h0;
      word_q  <= '0;
      wdata_q <= 32'h0;
      wmem_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            busy <= 1'b1;
            if (aligned) begin
              word_q  <= addr[DEPTH_LOG2+1:2];
              wdata_q <= wdata;
              wmem_q  <= wmem;
              cnt     <= WAIT_LOAD;
              state   <= ST_WAIT;
            end else begin
              ack   <= 1'b1;
              err   <= 1'b1;
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!wmem_q) rdata <= mem_rdata;
            ack   <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level reference model plus directed literal checks.
module tb_dmem_responder;

  localparam int WAIT_A = 2;

  logic        clk = 1'b0;
  logic        reset_0 = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        wmem = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, ack_b, busy_a, busy_b, err_a, err_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(6), .WAIT(WAIT_A)) u_dut_a (
    .clock(clk), .reset_0(reset_0), .req(req_a), .wmem(wmem), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .err(err_a));

  dmem_responder #(.DEPTH_LOG2(6), .WAIT(0)) u_dut_b (
    .clock(clk), .reset_0(reset_0), .req(req_b), .wmem(wmem), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .err(err_b));

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model of u_dut_a: each accepted request owns a
  // completion edge; everything visible is derived from that edge number.
  int          n_edge = 0;
  bit          m_act = 1'b0;
  int          m_end = 0;
  bit          m_mis, m_wr;
  int          m_word;
  logic [31:0] m_data;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_mem [64];

  always @(posedge clk) begin
    n_edge++;
    if (!reset_0) begin
      m_act   = 1'b0;
      m_rdata = 32'h0;
    end else begin
      if (m_act && n_edge == m_end && !m_mis) begin
        if (m_wr) m_mem[m_word] = m_data;
        else      m_rdata = m_mem[m_word];
      end
      if (req_a && (!m_act || n_edge >= m_end + 2)) begin
        m_act  = 1'b1;
        m_mis  = (addr[1:0] != 2'b00);
        m_end  = m_mis ? n_edge : n_edge + WAIT_A + 1;
        m_wr   = wmem;
        m_word = int'(addr[7:2]);
        m_data = wdata;
      end
    end
    #1;
    cmp("m_ack",   {31'h0, ack_a},  {31'h0, (m_act && n_edge == m_end)});
    cmp("m_busy",  {31'h0, busy_a}, {31'h0, (m_act && n_edge <= m_end)});
    cmp("m_err",   {31'h0, err_a},  {31'h0, (m_act && n_edge == m_end && m_mis)});
    cmp("m_rdata", rdata_a, m_rdata);
  end

  // One access on the selected DUT; lat counts edges after acceptance until ack is seen.
  // Inputs are scrambled right after acceptance to show they are not re-sampled.
  task automatic do_access(input bit sel, input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic e, output logic [31:0] rd);
    @(negedge clk);
    wmem  = wr;
    addr  = a;
    wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk);
    #1;
    req_a = 1'b0;
    req_b = 1'b0;
    addr  = $urandom;
    wdata = $urandom;
    wmem  = 1'($urandom_range(0, 1));
    lat = 0;
    while (!(sel ? ack_b : ack_a) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e  = sel ? err_b : err_a;
    rd = sel ? rdata_b : rdata_a;
    if (lat >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack within %0d cycles, required one", lat);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    logic        e;
    logic [31:0] rd;
    int          ack_cnt, first_ack, second_ack;
    logic [31:0] r;

    // reset
    reset_0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_rdata", rdata_a, 32'h0);
    cmp("rst_busy",  {31'h0, busy_a}, 32'h0);
    cmp("rst_ack",   {31'h0, ack_a},  32'h0);
    cmp("rst_err",   {31'h0, err_a},  32'h0);
    @(negedge clk);
    reset_0 = 1'b1;

    // give every word a known value
    for (int i = 0; i < 64; i++) do_access(1'b0, 1'b1, 32'(i * 4), $urandom, lat, e, rd);

    // write then read, WAIT=2
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, e, rd);
    cmp("wr_lat", 32'(lat), 32'd3);
    cmp("wr_err", {31'h0, e}, 32'h0);
    do_access(1'b0, 1'b0, 32'h10, 32'h0, lat, e, rd);
    cmp("rd_lat",   32'(lat), 32'd3);
    cmp("rd_data",  rd, 32'hDEADBEEF);
    cmp("rd_err",   {31'h0, e}, 32'h0);

    // misaligned
    do_access(1'b0, 1'b0, 32'h13, 32'h0, lat, e, rd);
    cmp("mis_lat",   32'(lat), 32'd0);
    cmp("mis_err",   {31'h0, e}, 32'h1);
    cmp("mis_rdata", rd, 32'hDEADBEEF);
    do_access(1'b0, 1'b0, 32'h10, 32'h0, lat, e, rd);
    cmp("after_mis_data", rd, 32'hDEADBEEF);
    cmp("after_mis_err",  {31'h0, e}, 32'h0);

    // req held for 10 cycles while busy
    @(negedge clk);
    wmem = 1'b0; addr = 32'h20; req_a = 1'b1;
    ack_cnt = 0; first_ack = -1; second_ack = -1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      if (ack_a) begin
        ack_cnt++;
        if (first_ack < 0) first_ack = j; else second_ack = j;
      end
    end
    req_a = 1'b0;
    cmp("hold_acks",    32'(ack_cnt), 32'd2);
    cmp("hold_spacing", 32'(second_ack - first_ack), 32'(WAIT_A + 3));
    repeat (3) @(posedge clk);

    // reset during WAIT aborts the write
    do_access(1'b0, 1'b1, 32'h8, 32'h0BADF00D, lat, e, rd);
    @(negedge clk);
    wmem = 1'b1; addr = 32'h8; wdata = 32'h1234; req_a = 1'b1;
    @(posedge clk);
    #1;
    req_a = 1'b0;
    cmp("abort_busy", {31'h0, busy_a}, 32'h1);
    ack_cnt = 0;
    @(negedge clk);
    reset_0 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (ack_a) ack_cnt++;
    end
    @(negedge clk);
    reset_0 = 1'b1;
    cmp("abort_rdata", rdata_a, 32'h0);
    cmp("abort_busy0", {31'h0, busy_a}, 32'h0);
    repeat (5) begin
      @(posedge clk);
      #1;
      if (ack_a) ack_cnt++;
    end
    cmp("abort_no_ack", 32'(ack_cnt), 32'd0);
    do_access(1'b0, 1'b0, 32'h8, 32'h0, lat, e, rd);
    cmp("abort_old_data", rd, 32'h0BADF00D);

    // inputs changing after acceptance
    do_access(1'b0, 1'b1, 32'h44, 32'h55556666, lat, e, rd);
    do_access(1'b0, 1'b1, 32'h40, 32'h11112222, lat, e, rd);
    do_access(1'b0, 1'b0, 32'h40, 32'h0, lat, e, rd);
    cmp("latch_data", rd, 32'h11112222);
    do_access(1'b0, 1'b0, 32'h44, 32'h0, lat, e, rd);
    cmp("latch_other", rd, 32'h55556666);

    // randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      reset_0 = ($urandom_range(0, 59) != 0);
      req_a   = ($urandom_range(0, 2) != 0);
      wmem    = 1'($urandom_range(0, 1));
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[7:2] = 6'($urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0) r[1:0] = 2'b00;
      addr  = r;
      wdata = $urandom;
    end
    @(negedge clk);
    reset_0 = 1'b1;
    req_a   = 1'b0;
    repeat (10) @(posedge clk);

    // WAIT=0 instance, aliasing through upper address bits
    do_access(1'b1, 1'b1, 32'h100, 32'hA5A5A5A5, lat, e, rd);
    cmp("w0_wr_lat", 32'(lat), 32'd1);
    cmp("w0_wr_err", {31'h0, e}, 32'h0);
    do_access(1'b1, 1'b0, 32'h0, 32'h0, lat, e, rd);
    cmp("w0_rd_lat",  32'(lat), 32'd1);
    cmp("w0_rd_data", rd, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 6, SHALL set the word depth to 2^DEPTH_LOG2.
REQ-002 Parameter WAIT, default 2, range 0..15, SHALL set the number of added wait cycles per access.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_0  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req  input  1  SHALL request an access; it is sampled only in IDLE.
REQ-006 wmem  input  1  SHALL select the access type: 1 = write, 0 = read; sampled with req.
REQ-007 addr  input  32  SHALL be the byte address; bits [DEPTH_LOG2+1:2] index the word, bits [1:0] are the alignment check, and upper bits are ignored (aliasing).
REQ-008 wdata  input  32  SHALL be the write data; sampled with req.
REQ-009 rdata  output  32  SHALL be the read data; registered.
REQ-010 ack  output  1  SHALL be a one-cycle completion pulse.
REQ-011 busy  output  1  SHALL be 1 in every state except IDLE, so the CPU can stall on it.
REQ-012 err  output  1  SHALL flag a misaligned access; it is valid only while ack=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 IDLE with req=1 and addr[1:0]==0 SHALL latch addr, wdata and wmem, load cnt=WAIT, and go to WAIT.
REQ-015 IDLE with req=1 and addr[1:0]!=0 SHALL go directly to RESP with err=1; no memory access takes place.
REQ-016 WAIT with cnt!=0 SHALL decrement cnt and stay in WAIT.
REQ-017 WAIT with cnt==0 SHALL perform the access on that edge and go to RESP.
  - Write: mem[word] <= latched wdata.
  - Read: rdata <= mem[word].
REQ-018 RESP SHALL drive ack=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-019 Aligned-access latency: with acceptance at edge E, the access SHALL occur at edge E+WAIT+1, and ack SHALL be high in the cycle following that edge.
REQ-020 Misaligned latency: ack SHALL be high in the cycle following the acceptance edge.
REQ-021 Request handling:
  - req asserted while busy=1 SHALL be ignored and not queued.
  - A new request SHALL be accepted at the earliest in the IDLE cycle that follows RESP.
  - Back-to-back throughput SHALL therefore be one access per WAIT+3 cycles.
REQ-022 rdata SHALL change only on a completed aligned read; it holds its value across writes, errors and idle cycles.
REQ-023 err SHALL be 0 whenever ack=0.
REQ-024 Read-after-write to the same word in consecutive transactions SHALL return the newly written data.
REQ-025 Changes on addr, wdata or wmem after acceptance SHALL NOT affect the transaction in flight.

Reset
REQ-026 reset_0=0 at a rising edge SHALL force:
  - state=IDLE, cnt=0;
  - ack=0, err=0, busy=0;
  - rdata=32'h0.
REQ-027 Reset SHALL NOT clear memory contents.
REQ-028 Reset asserted while in WAIT SHALL abort the transaction: no write occurs and no ack is produced.
REQ-029 A req present on the first edge with reset_0=1 SHALL be accepted normally.

Structure
REQ-030 The shared package SHALL hold:
  - the state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10);
  - the DEPTH_LOG2 and WAIT defaults.
REQ-031 Storage SHALL be a sub-module dmem_array with:
  - synchronous write and asynchronous read;
  - ports clock, we, waddr, wdata, raddr, rdata;
  - no reset.
REQ-032 The FSM, counter and request latch SHALL reside in dmem_responder.

Verification
REQ-033 Write then read, WAIT=2: write addr=0x10, wdata=0xDEADBEEF; then read addr=0x10 -> each ack appears 3 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-034 Misaligned access: read addr=0x13 -> ack on the next cycle with err=1, rdata unchanged; a subsequent read of word 4 is unaffected.
REQ-035 Busy ignore: hold req=1 for 10 cycles with addr=0x20 -> exactly two acks occur, spaced WAIT+3=5 cycles apart.
REQ-036 Reset mid-operation: write 0x1234 to addr=0x8 and pull reset_0 low during WAIT -> no ack; a later read of 0x8 returns the prior contents; after reset, rdata=0 and busy=0.
REQ-037 WAIT=0 aliasing: write 0xA5A5A5A5 to addr=0x100 (aliases word 0 at DEPTH_LOG2=6); read addr=0x0 -> 0xA5A5A5A5, with ack one cycle after the access edge.
REQ-038 Input change after acceptance: change addr and wdata on the cycle after acceptance -> the original address and data are written.
